alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Decode/issue stage that produces the ALU's input interface (alu_op, in_a, in_b).
//  Accepts one RV32I instruction plus register-file read data per handshake.
//  Decodes R-type ADD/SUB/AND/OR and I-type ADDI/ANDI/ORI into alu_op_t and operands.
//  Registers the result toward the execute stage with valid/ready flow control.
// PARAMETERS
//  XLEN     32  datapath width; must match the ALU's in_a/in_b/result width
//  CNT_W    16  width of the issued-instruction performance counter
// PORTS
//  clk            in   1      system clock, rising edge
//  rst_n          in   1      asynchronous reset, active-low
//  in_valid       in   1      upstream instruction/operands valid
//  in_ready       out  1      stage can accept this cycle
//  instr          in   32     RV32I instruction word
//  rs1_data       in   XLEN   register-file value for instr[19:15]
//  rs2_data       in   XLEN   register-file value for instr[24:20]
//  flush          in   1      kill the held entry and any instruction accepted this cycle
//  out_valid      out  1      alu_op/in_a/in_b/rd_addr valid toward execute
//  out_ready      in   1      execute stage consumes this cycle
//  alu_op         out  4      alu_op_t (riscv_32i_defs_pkg) sent to the ALU
//  in_a           out  XLEN   ALU operand A
//  in_b           out  XLEN   ALU operand B
//  rd_addr        out  5      destination register instr[11:7]
//  illegal_instr  out  1      one-cycle pulse: an unsupported instruction was consumed
//  issue_count    out  CNT_W  number of entries issued (out_valid & out_ready)
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, illegal_instr=0, issue_count=0, alu_op=ALU_ADD,
//    in_a=0, in_b=0, rd_addr=0. Reset mid-transfer discards the held entry.
//  States: EMPTY (out_valid=0), FULL (out_valid=1). Single entry, no skid buffer.
//  in_ready = !out_valid | out_ready (combinational from out_ready).
//  Accept = in_valid & in_ready. Issue = out_valid & out_ready.
//  Decode (opcode=instr[6:0], f3=instr[14:12], f7=instr[31:25]):
//    0110011 f3=000 f7=0000000 -> ALU_ADD; f3=000 f7=0100000 -> ALU_SUB;
//    0110011 f3=111 f7=0 -> ALU_AND; f3=110 f7=0 -> ALU_OR; in_b = rs2_data.
//    0010011 f3=000 -> ALU_ADD; f3=111 -> ALU_AND; f3=110 -> ALU_OR;
//      in_b = sign-extended instr[31:20] to XLEN (bit 31 replicated).
//    in_a = rs1_data for all legal instructions.
//    Anything else is illegal (including R-type with other f7 and all other opcodes).
//  Latency: legal accept at edge N -> out_valid=1 with decoded fields after edge N.
//  Next-state at each edge, priority order:
//    flush=1: out_valid<=0; accepted instruction dropped; illegal_instr<=0.
//    legal accept: load outputs, out_valid<=1 (EMPTY->FULL or FULL->FULL when issued).
//    illegal accept: consumed, not loaded; illegal_instr<=1 for one cycle;
//      out_valid <= out_valid & !out_ready.
//    no accept: out_valid <= out_valid & !out_ready; outputs hold while FULL.
//  Issue in the same cycle as a legal accept: back-to-back, out_valid stays 1.
//  While out_valid=1 & out_ready=0: alu_op/in_a/in_b/rd_addr are stable.
//  issue_count increments on every issue (including in a flush cycle) and wraps modulo 2^CNT_W.
//  rd_addr=0 instructions are issued normally (execute/writeback ignores x0).
//  alu_op never takes an undefined encoding (e.g. 4'b1111) on the output.
// TESTING
//  ADD x3,x1,x2 rs1=0x7FFFFFFF rs2=1, out_ready=1 -> next cycle ALU_ADD, a=7FFFFFFF, b=1, rd=3.
//  ADDI x5,x1,-1 (imm=0xFFF) rs1=5 -> in_b=0xFFFFFFFF, alu_op=ALU_ADD, rd_addr=5.
//  SUB then OR back-to-back, out_ready=1 -> out_valid high 2 cycles, issue_count=2.
//  out_ready=0 for 3 cycles after ANDI -> in_ready=0, outputs frozen; release -> one issue.
//  instr=0x00000073 (ECALL) -> illegal_instr pulses 1 cycle, out_valid stays 0, count unchanged.
//  flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle; rst_n=0 mid-stall -> all zero.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Decode/issue stage for the RV32I ALU subset: turns one instruction plus register
// operands into a registered alu_op/in_a/in_b/rd_addr entry with valid/ready handshake.

package riscv_32i_defs_pkg;
  // Encodings follow {funct7[5], funct3} so R-type decode maps straight onto them.
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b1000,
    ALU_AND = 4'b0111,
    ALU_OR  = 4'b0110
  } alu_op_t;
endpackage

module alu_issue_stage
  import riscv_32i_defs_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alu_op,
  output logic [XLEN-1:0]  in_a,
  output logic [XLEN-1:0]  in_b,
  output logic [4:0]       rd_addr,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q;
  alu_op_t          op_q, op_d;
  logic [XLEN-1:0]  a_q, b_q, b_d;
  logic [4:0]       rd_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             legal_d;
  logic             accept, issue;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_rs1_idx;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_rs1_idx = ^instr[19:15];

  assign out_valid     = (state_q == FULL);
  assign in_ready      = !out_valid || out_ready;
  assign accept        = in_valid && in_ready;
  assign issue         = out_valid && out_ready;
  assign alu_op        = op_q;
  assign in_a          = a_q;
  assign in_b          = b_q;
  assign rd_addr       = rd_q;
  assign illegal_instr = illegal_q;
  assign issue_count   = cnt_q;
  assign cnt_d         = cnt_q + CNT_W'(1);

  // Anything outside the supported subset is flagged illegal and never loaded.
  always_comb begin
    legal_d = 1'b0;
    op_d    = ALU_ADD;
    b_d     = rs2_data;
    if (opcode == OPC_OP) begin
      unique case (funct3)
        3'b000: begin
          legal_d = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
          op_d    = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
        end
        3'b111: begin
          legal_d = (funct7 == F7_ZERO);
          op_d    = ALU_AND;
        end
        3'b110: begin
          legal_d = (funct7 == F7_ZERO);
          op_d    = ALU_OR;
        end
        default: legal_d = 1'b0;
      endcase
    end else if (opcode == OPC_OP_IMM) begin
      b_d = {{(XLEN-12){instr[31]}}, instr[31:20]};
      unique case (funct3)
        3'b000:  begin legal_d = 1'b1; op_d = ALU_ADD; end
        3'b111:  begin legal_d = 1'b1; op_d = ALU_AND; end
        3'b110:  begin legal_d = 1'b1; op_d = ALU_OR;  end
        default: legal_d = 1'b0;
      endcase
    end
  end

  // Flush outranks everything except the counter, which still records a same-cycle issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      op_q      <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
    end else begin
      if (issue) begin
        cnt_q <= cnt_d;
      end
      if (flush) begin
        state_q   <= EMPTY;
        illegal_q <= 1'b0;
      end else if (accept && legal_d) begin
        state_q   <= FULL;
        illegal_q <= 1'b0;
        op_q      <= op_d;
        a_q       <= rs1_data;
        b_q       <= b_d;
        rd_q      <= instr[11:7];
      end else begin
        illegal_q <= accept;
        if (out_ready) begin
          state_q <= EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios followed by a randomised
// run with backpressure and flushes; the counter is narrowed so wrap-around is reached.
module tb_alu_issue_stage;
  import riscv_32i_defs_pkg::*;

  localparam int XL = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, flush, out_valid, out_ready, illegal_instr;
  logic [31:0]   instr, rs1_data, rs2_data, in_a, in_b;
  logic [3:0]    alu_op;
  logic [4:0]    rd_addr;
  logic [CW-1:0] issue_count;

  alu_issue_stage #(.XLEN(XL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
    .in_a(in_a), .in_b(in_b), .rd_addr(rd_addr),
    .illegal_instr(illegal_instr), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } entry_t;

  entry_t        sb[$];
  int            checks = 0;
  int            errors = 0;
  bit            mValid, mIll, randMode;
  logic [CW-1:0] mCnt;
  int            validCycles;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic void refDecode(input logic [31:0] ins, input logic [31:0] r1,
                                    input logic [31:0] r2, output bit legal, output entry_t e);
    legal = 1'b1;
    e.a   = r1;
    e.b   = r2;
    e.rd  = ins[11:7];
    e.op  = ALU_ADD;
    if (ins[6:0] == 7'h33) begin
      case ({ins[31:25], ins[14:12]})
        {7'h00, 3'd0}: e.op = ALU_ADD;
        {7'h20, 3'd0}: e.op = ALU_SUB;
        {7'h00, 3'd7}: e.op = ALU_AND;
        {7'h00, 3'd6}: e.op = ALU_OR;
        default:       legal = 1'b0;
      endcase
    end else if (ins[6:0] == 7'h13) begin
      e.b = 32'($signed(ins[31:20]));
      case (ins[14:12])
        3'd0:    e.op = ALU_ADD;
        3'd7:    e.op = ALU_AND;
        3'd6:    e.op = ALU_OR;
        default: legal = 1'b0;
      endcase
    end else begin
      legal = 1'b0;
    end
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    bit     legal, mAcc, mIss;
    entry_t e, exp;
    if (!rst_n) begin
      mValid = 1'b0;
      mIll   = 1'b0;
      mCnt   = '0;
      sb.delete();
    end else begin
      checkOutput("out_valid", 32'(out_valid), 32'(mValid));
      checkOutput("in_ready", 32'(in_ready), 32'(!mValid || out_ready));
      checkOutput("illegal_instr", 32'(illegal_instr), 32'(mIll));
      checkOutput("issue_count", 32'(issue_count), 32'(mCnt));
      mAcc = in_valid && (!mValid || out_ready);
      mIss = mValid && out_ready;
      if (mIss || (flush && mValid)) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'(0), 32'(1));
        end else begin
          exp = sb.pop_front();
          if (mIss) begin
            checkOutput("alu_op", 32'(alu_op), 32'(exp.op));
            checkOutput("in_a", in_a, exp.a);
            checkOutput("in_b", in_b, exp.b);
            checkOutput("rd_addr", 32'(rd_addr), 32'(exp.rd));
          end
        end
      end
      if (mIss) mCnt = mCnt + CW'(1);
      refDecode(instr, rs1_data, rs2_data, legal, e);
      if (flush) begin
        mValid = 1'b0;
        mIll   = 1'b0;
      end else if (mAcc && legal) begin
        sb.push_back(e);
        mValid = 1'b1;
        mIll   = 1'b0;
      end else begin
        mIll   = mAcc;
        mValid = mValid && !out_ready;
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid) validCycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randMode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    bit accepted = 1'b0;
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clk);
      accepted = in_ready;
      tick();
    end
    if (!accepted) checkOutput("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ri;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; randMode = 1'b0;
    instr = '0; rs1_data = '0; rs2_data = '0; validCycles = 0;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    checkOutput("rst_in_a", in_a, 32'(0));
    checkOutput("rst_rd", 32'(rd_addr), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'h7FFF_FFFF, 32'h1);
    checkOutput("add_op", 32'(alu_op), 32'(ALU_ADD));
    checkOutput("add_a", in_a, 32'h7FFF_FFFF);
    checkOutput("add_b", in_b, 32'h1);
    checkOutput("add_rd", 32'(rd_addr), 32'd3);
    tick();

    applyStimulus(iType(12'hFFF, 5'd1, 3'd0, 5'd5), 32'd5, 32'h1234);
    checkOutput("addi_b", in_b, 32'hFFFF_FFFF);
    checkOutput("addi_rd", 32'(rd_addr), 32'd5);
    tick();

    validCycles = 0;
    applyStimulus(rType(7'h20, 5'd4, 5'd6, 3'd0, 5'd8), 32'd100, 32'd30);
    applyStimulus(rType(7'h00, 5'd4, 5'd6, 3'd6, 5'd9), 32'hF0, 32'h0F);
    repeat (3) tick();
    checkOutput("b2b_valid_cycles", 32'(validCycles), 32'd2);

    out_ready = 1'b0;
    applyStimulus(iType(12'h0F0, 5'd2, 3'd7, 5'd7), 32'hABCD_1234, 32'h0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_op", 32'(alu_op), 32'(ALU_AND));
      checkOutput("stall_b", in_b, 32'h0000_00F0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("release_empty", 32'(out_valid), 32'd0);

    applyStimulus(32'h0000_0073, 32'd1, 32'd2);
    checkOutput("ecall_pulse", 32'(illegal_instr), 32'd1);
    checkOutput("ecall_no_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("ecall_pulse_end", 32'(illegal_instr), 32'd0);

    out_ready = 1'b0;
    applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd0, 5'd4), 32'd7, 32'd8);
    instr = iType(12'h00F, 5'd3, 3'd6, 5'd10); in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_held", 32'(out_valid), 32'd0);

    applyStimulus(rType(7'h00, 5'd2, 5'd1, 3'd7, 5'd11), 32'hFF00, 32'h0FF0);
    out_ready = 1'b1; instr = iType(12'h001, 5'd3, 3'd0, 5'd12); in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_issue", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    applyStimulus(iType(12'h800, 5'd2, 3'd7, 5'd13), 32'hFFFF_FFFF, 32'h0);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_count", 32'(issue_count), 32'd0);
    checkOutput("midrst_b", in_b, 32'd0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();

    randMode = 1'b1;
    for (int k = 0; k < 80; k++) begin
      ri = $urandom;
      case ($urandom_range(0, 9))
        0: instr = rType(7'h00, ri[24:20], ri[19:15], 3'd0, ri[11:7]);
        1: instr = rType(7'h20, ri[24:20], ri[19:15], 3'd0, ri[11:7]);
        2: instr = rType(7'h00, ri[24:20], ri[19:15], 3'd7, ri[11:7]);
        3: instr = rType(7'h00, ri[24:20], ri[19:15], 3'd6, ri[11:7]);
        4: instr = iType(ri[31:20], ri[19:15], 3'd0, ri[11:7]);
        5: instr = iType(ri[31:20], ri[19:15], 3'd7, ri[11:7]);
        6: instr = iType(ri[31:20], ri[19:15], 3'd6, ri[11:7]);
        7: instr = rType(7'h20, ri[24:20], ri[19:15], 3'd7, ri[11:7]);
        8: instr = iType(ri[31:20], ri[19:15], 3'd1, ri[11:7]);
        default: instr = ri;
      endcase
      applyStimulus(instr, $urandom, $urandom);
    end
    randMode = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    checkOutput("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
